order_dispatch: RTL and testbench

//  Read-side sequencer for the order cache. On task_start it pops orders one at a time,

---
 rtl/order_dispatch_if.sv | 30 +++
 rtl/order_dispatch.sv | 125 ++++++++++++
 tb/tb_order_dispatch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/order_dispatch_if.sv
// Bundle between the order dispatcher and its host / order cache / compute engine.
// Strobes are single-cycle pulses with no back-pressure: task_start, calc_done, pop_order_en,
// task_done and task_error are each acted on in the cycle they are high; order/id are valid
// in the cycle after pop_order_en; there is no ready, so a pulse sent while the receiver
// cannot use it is dropped.
interface order_dispatch_if #(
  parameter int ADDR_W = 9
);
  logic              task_start;
  logic [2:0]        order;
  logic [7:0]        id;
  logic              calc_done;
  logic              pop_order_en;
  logic              busy;
  logic              task_done;
  logic              task_error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   order_count;
  logic [7:0]        current_id;

  modport master (
    input  task_start, order, id, calc_done,
    output pop_order_en, busy, task_done, task_error, err_code, order_count, current_id
  );

  modport slave (
    output task_start, order, id, calc_done,
    input  pop_order_en, busy, task_done, task_error, err_code, order_count, current_id
  );
endinterface

// File: rtl/order_dispatch.sv
// Read-side sequencer for the order cache: pops orders one at a time, waits for the
// compute engine on each, and ends on the END order (code 5) or on an error.
module order_dispatch #(
  parameter int                   ADDR_W    = 9,
  parameter int                   TIMEOUT_W = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = '1
) (
  input  logic              system_clk,
  input  logic              rst,
  order_dispatch_if.master  bus,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_CHECK  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4,
    S_FAIL   = 3'd5
  } state_e;

  // order_count is one bit wider than ADDR_W so it can hold MAX_ORDERS itself.
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  state_e                state_q, state_d;
  logic [1:0]            err_q, err_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic [7:0]            id_q, id_d;
  logic                  flag_q, flag_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      id_q    <= '0;
      flag_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      flag_q  <= flag_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    flag_d  = flag_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (bus.task_start) begin
          state_d = S_POP;
          err_d   = ERR_NONE;
          cnt_d   = '0;
          flag_d  = 1'b0;
          wd_d    = '0;
        end
      end
      S_POP: begin
        if (cnt_q != MAX_CNT) cnt_d = cnt_q + (ADDR_W+1)'(1);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        id_d = bus.id;
        wd_d = '0;
        // Remember a same-cycle completion so a one-cycle engine is not missed in WAIT.
        if (bus.calc_done) flag_d = 1'b1;
        case (bus.order)
          3'd5:                      state_d = S_FINISH;
          3'd1, 3'd2, 3'd3, 3'd4:    state_d = S_WAIT;
          default: begin
            state_d = S_FAIL;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_WAIT: begin
        if (flag_q || bus.calc_done) begin
          flag_d = 1'b0;
          wd_d   = '0;
          if (cnt_q == MAX_CNT) begin
            state_d = S_FAIL;
            err_d   = ERR_OVERRUN;
          end else begin
            state_d = S_POP;
          end
        end else if (wd_q == TIMEOUT) begin
          state_d = S_FAIL;
          err_d   = ERR_TIMEOUT;
        end else begin
          wd_d = wd_q + TIMEOUT_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pop_order_en = (state_q == S_POP);
    bus.busy         = (state_q != S_IDLE);
    bus.task_done    = (state_q == S_FINISH);
    bus.task_error   = (state_q == S_FAIL);
    bus.err_code     = err_q;
    bus.order_count  = cnt_q;
    bus.current_id   = id_q;
    dbg_state_o      = state_q;
  end

endmodule

// File: tb/tb_order_dispatch.sv
// Bench for order_dispatch: directed and random order lists checked against a timing model
// derived from the sequencing rules (pop/check/wait cycle arithmetic).
module tb_order_dispatch;
  localparam int ADDR_W     = 2;
  localparam int MAX_ORDERS = 4;
  localparam int TIMEOUT    = 16;
  localparam int NEVER      = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  order_dispatch_if #(.ADDR_W(ADDR_W)) bus ();

  order_dispatch #(
    .ADDR_W   (ADDR_W),
    .TIMEOUT_W(5),
    .TIMEOUT  (5'd16)
  ) dut (
    .system_clk (clk),
    .rst        (rst),
    .bus        (bus.master),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int ord_l[$];
  int id_l[$];
  int dly_l[$];
  logic [15:0] exp_q[$];
  int exp_end, exp_kind, exp_err, exp_cnt, exp_id;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ord_at(input int i);
    return (i < ord_l.size()) ? ord_l[i] : 5;
  endfunction
  function automatic int id_at(input int i);
    return (i < id_l.size()) ? id_l[i] : 0;
  endfunction
  function automatic int dly_at(input int i);
    return (i < dly_l.size()) ? dly_l[i] : NEVER;
  endfunction

  // Reference timing: task_start in cycle 0, first pop in cycle 1, CHECK one cycle after
  // each pop, WAIT from CHECK+1; calc_done d cycles after CHECK is seen at CHECK+max(1,d),
  // and is honoured while the watchdog has not passed TIMEOUT (d <= TIMEOUT+1).
  task automatic build_model();
    int p, c, d, o, h;
    exp_q.delete();
    p = 1;
    exp_end = 0; exp_kind = 0; exp_err = 0; exp_cnt = 0; exp_id = 0;
    for (int i = 0; i < MAX_ORDERS; i++) begin
      exp_q.push_back(16'(p));
      c       = p + 1;
      exp_cnt = i + 1;
      exp_id  = id_at(i);
      o       = ord_at(i);
      if (o == 5) begin
        exp_end = c + 1; exp_kind = 1; exp_err = 0; break;
      end
      if (o == 0 || o >= 6) begin
        exp_end = c + 1; exp_kind = 2; exp_err = 1; break;
      end
      d = dly_at(i);
      if (d > TIMEOUT + 1) begin
        exp_end = c + 1 + TIMEOUT + 1; exp_kind = 2; exp_err = 2; break;
      end
      h = c + ((d < 1) ? 1 : d);
      if (i + 1 == MAX_ORDERS) begin
        exp_end = h + 1; exp_kind = 2; exp_err = 3; break;
      end
      p = h + 1;
    end
  endtask

  task automatic clear_inputs();
    bus.task_start = 1'b0;
    bus.calc_done  = 1'b0;
    bus.order      = 3'd0;
    bus.id         = 8'd0;
  endtask

  // Drives one task cycle by cycle: inputs set at the negedge of cycle n act at the
  // posedge ending cycle n; outputs read at that negedge belong to cycle n.
  task automatic run_task(input int extra_start_cyc);
    bit pop_prev = 1'b0;
    bit ended    = 1'b0;
    int done_cyc = -1;
    int n_pop    = 0;
    int cyc;
    int d, o;
    build_model();
    for (cyc = 0; cyc < 200 && !ended; cyc++) begin
      @(negedge clk);
      check("busy", bus.busy, (cyc >= 1) ? 1 : 0);
      if (cyc == 1) check("err_clear", bus.err_code, 0);
      if (bus.pop_order_en) begin
        check("pop_spacing", pop_prev, 0);
        if (exp_q.size() != 0) check("pop_cycle", cyc, int'(exp_q.pop_front()));
        else                   check("pop_cycle", cyc, -1);
      end
      if (bus.task_done || bus.task_error) begin
        check("end_cycle", cyc, exp_end);
        check("end_kind", bus.task_done ? 1 : 2, exp_kind);
        check("end_both", bus.task_done & bus.task_error, 0);
        check("err_code", bus.err_code, exp_err);
        check("order_count", bus.order_count, exp_cnt);
        check("current_id", bus.current_id, exp_id);
        check("pops_left", exp_q.size(), 0);
        ended = 1'b1;
      end
      // Cache presents the popped order one cycle after the strobe.
      if (pop_prev) begin
        bus.order = 3'(ord_at(n_pop));
        bus.id    = 8'(id_at(n_pop));
        o = ord_at(n_pop);
        d = dly_at(n_pop);
        done_cyc = (o >= 1 && o <= 4 && d < NEVER) ? cyc + d : -1;
        n_pop++;
      end
      pop_prev       = bus.pop_order_en;
      bus.task_start = (cyc == 0) || (cyc == extra_start_cyc);
      bus.calc_done  = (cyc == done_cyc);
    end
    if (!ended) check("end_timeout", cyc, exp_end);
    @(negedge clk);
    clear_inputs();
    check("busy_after", bus.busy, 0);
    check("pulse_after", bus.task_done | bus.task_error, 0);
    check("err_hold", bus.err_code, exp_err);
    check("count_hold", bus.order_count, exp_cnt);
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  bus.busy, 0);
    check({tag, "_pop"},   bus.pop_order_en, 0);
    check({tag, "_done"},  bus.task_done, 0);
    check({tag, "_error"}, bus.task_error, 0);
    check({tag, "_err"},   bus.err_code, 0);
    check({tag, "_cnt"},   bus.order_count, 0);
    check({tag, "_id"},    bus.current_id, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int r, len;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    // Three orders, engine done 4 cycles after each CHECK.
    ord_l = '{1, 2, 5}; id_l = '{11, 12, 13}; dly_l = '{4, 4, 0};
    run_task(-1);
    // END only.
    ord_l = '{5}; id_l = '{21}; dly_l = '{0};
    run_task(-1);
    // Illegal second order.
    ord_l = '{3, 0}; id_l = '{31, 32}; dly_l = '{2, 0};
    run_task(-1);
    // Watchdog: never done, then done exactly at the limit, then one past it.
    ord_l = '{1, 5}; id_l = '{41, 42}; dly_l = '{NEVER, 0};
    run_task(-1);
    dly_l = '{TIMEOUT + 1, 0};
    run_task(-1);
    dly_l = '{TIMEOUT + 2, 0};
    run_task(-1);
    // Same-cycle completion plus a start request while busy.
    ord_l = '{1, 5}; id_l = '{51, 52}; dly_l = '{0, 0};
    run_task(3);
    // Four non-END orders overrun the cache.
    ord_l = '{1, 2, 3, 4}; id_l = '{61, 62, 63, 64}; dly_l = '{1, 2, 3, 1};
    run_task(-1);

    for (int t = 0; t < 30; t++) begin
      ord_l.delete(); id_l.delete(); dly_l.delete();
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       ord_l.push_back((r % 4) + 1);
        else if (r < 8)  ord_l.push_back(5);
        else if (r == 8) ord_l.push_back(0);
        else             ord_l.push_back($urandom_range(6, 7));
        id_l.push_back($urandom_range(0, 255));
        r = $urandom_range(0, 19);
        if (r < 14)      dly_l.push_back(r % 7);
        else if (r < 16) dly_l.push_back(TIMEOUT + 1);
        else if (r < 18) dly_l.push_back(TIMEOUT + 2);
        else             dly_l.push_back(NEVER);
      end
      run_task((t % 5 == 0) ? $urandom_range(1, 6) : -1);
    end

    // Reset in the middle of WAIT: everything back to zero, no further pops.
    @(negedge clk);
    bus.task_start = 1'b1;
    @(negedge clk);
    bus.task_start = 1'b0;
    @(negedge clk);
    bus.order = 3'd2;
    bus.id    = 8'd77;
    repeat (3) @(negedge clk);
    check("mid_wait_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_idle_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_pop", bus.pop_order_en, 0);
      check("post_rst_busy", bus.busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
